ex_stage_ctrl: RTL and testbench

Execute-stage controller for the 5-stage pipelined MIPS core. It holds the ID/EX pipeline register and decodes the 4-bit ALU operation. It resolves operand forwarding from EX/MEM and MEM/WB and drives the combinational ALU (in0/in1/alu_op). It captures the ALU result into the EX/MEM pipeline register, detects load-use hazards and reports them to the fetch/decode stages.

---
 rtl/ex_stage_ctrl_if.sv | 71 +++++++
 rtl/ex_stage_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_ex_stage_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ex_stage_ctrl_if : decode, writeback, ALU and EX/MEM signal bundle    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
interface ex_stage_ctrl_if #(
  parameter int W  = 32,
  parameter int RA = 5
);
  logic          stall;
  logic          flush;
  logic [W-1:0]  id_rs_data;
  logic [W-1:0]  id_rt_data;
  logic [W-1:0]  id_imm;
  logic [RA-1:0] id_rs;
  logic [RA-1:0] id_rt;
  logic [RA-1:0] id_rd;
  logic [1:0]    id_aluop;
  logic [5:0]    id_funct;
  logic          id_alusrc;
  logic          id_regdst;
  logic          id_regwrite;
  logic          id_memread;
  logic          id_memwrite;
  logic          id_memtoreg;
  logic          id_valid;
  logic          wb_regwrite;
  logic [RA-1:0] wb_rd;
  logic [W-1:0]  wb_data;
  logic [W-1:0]  alu_in0;
  logic [W-1:0]  alu_in1;
  logic [3:0]    alu_op;
  logic [W-1:0]  alu_res;
  logic          alu_zero;
  logic          load_use;
  logic          mem_valid;
  logic          mem_regwrite;
  logic          mem_memread;
  logic          mem_memwrite;
  logic          mem_memtoreg;
  logic [W-1:0]  mem_alu_res;
  logic          mem_zero;
  logic [W-1:0]  mem_store_data;
  logic [RA-1:0] mem_rd;
  logic          illegal_funct;

  modport master (
    output stall, flush,
    output id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
    output id_aluop, id_funct, id_alusrc, id_regdst, id_regwrite,
    output id_memread, id_memwrite, id_memtoreg, id_valid,
    output wb_regwrite, wb_rd, wb_data,
    output alu_res, alu_zero,
    input  alu_in0, alu_in1, alu_op, load_use,
    input  mem_valid, mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg,
    input  mem_alu_res, mem_zero, mem_store_data, mem_rd, illegal_funct
  );

  modport slave (
    input  stall, flush,
    input  id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
    input  id_aluop, id_funct, id_alusrc, id_regdst, id_regwrite,
    input  id_memread, id_memwrite, id_memtoreg, id_valid,
    input  wb_regwrite, wb_rd, wb_data,
    input  alu_res, alu_zero,
    output alu_in0, alu_in1, alu_op, load_use,
    output mem_valid, mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg,
    output mem_alu_res, mem_zero, mem_store_data, mem_rd, illegal_funct
  );
endinterface
`default_nettype wire

// File: rtl/ex_stage_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ex_stage_ctrl : MIPS execute stage - ID/EX and EX/MEM registers,      |
// | ALU op decode, operand forwarding and load-use hazard detection.      |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module ex_stage_ctrl #(
  parameter int W  = 32,
  parameter int RA = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  ex_stage_ctrl_if.slave bus
);

  localparam logic [3:0] c_ALU_AND = 4'b0000;
  localparam logic [3:0] c_ALU_OR  = 4'b0001;
  localparam logic [3:0] c_ALU_ADD = 4'b0010;
  localparam logic [3:0] c_ALU_SUB = 4'b0110;
  localparam logic [3:0] c_ALU_SLT = 4'b0111;
  localparam logic [3:0] c_ALU_NOR = 4'b1100;

  localparam logic [5:0] c_FN_ADD = 6'b100000;
  localparam logic [5:0] c_FN_SUB = 6'b100010;
  localparam logic [5:0] c_FN_AND = 6'b100100;
  localparam logic [5:0] c_FN_OR  = 6'b100101;
  localparam logic [5:0] c_FN_SLT = 6'b101010;
  localparam logic [5:0] c_FN_NOR = 6'b100111;

  localparam logic [1:0] c_OP_ADD   = 2'b00;
  localparam logic [1:0] c_OP_SUB   = 2'b01;
  localparam logic [1:0] c_OP_RTYPE = 2'b10;
  localparam logic [1:0] c_OP_OR    = 2'b11;

  typedef struct packed {
    logic          valid;
    logic [W-1:0]  rs_data;
    logic [W-1:0]  rt_data;
    logic [W-1:0]  imm;
    logic [RA-1:0] rs;
    logic [RA-1:0] rt;
    logic [RA-1:0] rd;
    logic [1:0]    aluop;
    logic [5:0]    funct;
    logic          alusrc;
    logic          regdst;
    logic          regwrite;
    logic          memread;
    logic          memwrite;
    logic          memtoreg;
  } id_ex_t;

  typedef struct packed {
    logic          valid;
    logic          regwrite;
    logic          memread;
    logic          memwrite;
    logic          memtoreg;
    logic          zero;
    logic          illegal;
    logic [W-1:0]  alu_res;
    logic [W-1:0]  store_data;
    logic [RA-1:0] rd;
  } ex_mem_t;

  id_ex_t  id_ex_q,  id_ex_d;
  ex_mem_t ex_mem_q, ex_mem_d;

  logic [3:0]   w_alu_op;
  logic         w_funct_bad;
  logic         w_illegal;
  logic         w_rs_fwd_mem, w_rs_fwd_wb;
  logic         w_rt_fwd_mem, w_rt_fwd_wb;
  logic [W-1:0] w_rs_val, w_rt_val;
  logic         w_load_use;

  // Unknown R-type functs fall back to add; the error travels with the instruction.
  always_comb begin
    w_alu_op    = c_ALU_ADD;
    w_funct_bad = 1'b0;
    case (id_ex_q.aluop)
      c_OP_ADD: w_alu_op = c_ALU_ADD;
      c_OP_SUB: w_alu_op = c_ALU_SUB;
      c_OP_OR:  w_alu_op = c_ALU_OR;
      c_OP_RTYPE: begin
        case (id_ex_q.funct)
          c_FN_ADD: w_alu_op = c_ALU_ADD;
          c_FN_SUB: w_alu_op = c_ALU_SUB;
          c_FN_AND: w_alu_op = c_ALU_AND;
          c_FN_OR:  w_alu_op = c_ALU_OR;
          c_FN_SLT: w_alu_op = c_ALU_SLT;
          c_FN_NOR: w_alu_op = c_ALU_NOR;
          default:  w_funct_bad = 1'b1;
        endcase
      end
      default: w_alu_op = c_ALU_ADD;
    endcase
  end

  assign w_illegal = w_funct_bad & id_ex_q.valid;

  // EX/MEM is younger than MEM/WB, so it takes priority; $0 is never forwarded.
  assign w_rs_fwd_mem = ex_mem_q.regwrite && (ex_mem_q.rd != '0) && (ex_mem_q.rd == id_ex_q.rs);
  assign w_rs_fwd_wb  = bus.wb_regwrite && (bus.wb_rd != '0) && (bus.wb_rd == id_ex_q.rs);
  assign w_rt_fwd_mem = ex_mem_q.regwrite && (ex_mem_q.rd != '0) && (ex_mem_q.rd == id_ex_q.rt);
  assign w_rt_fwd_wb  = bus.wb_regwrite && (bus.wb_rd != '0) && (bus.wb_rd == id_ex_q.rt);

  assign w_rs_val = w_rs_fwd_mem ? ex_mem_q.alu_res :
                    w_rs_fwd_wb  ? bus.wb_data      : id_ex_q.rs_data;
  assign w_rt_val = w_rt_fwd_mem ? ex_mem_q.alu_res :
                    w_rt_fwd_wb  ? bus.wb_data      : id_ex_q.rt_data;

  assign w_load_use = id_ex_q.valid && id_ex_q.memread && (id_ex_q.rt != '0) && bus.id_valid &&
                      ((id_ex_q.rt == bus.id_rs) || (id_ex_q.rt == bus.id_rt));

  always_comb begin
    id_ex_d = id_ex_q;
    if (bus.stall) begin
      id_ex_d = id_ex_q;
    end else if (bus.flush || w_load_use) begin
      id_ex_d = '0;
    end else begin
      id_ex_d.valid    = bus.id_valid;
      id_ex_d.rs_data  = bus.id_rs_data;
      id_ex_d.rt_data  = bus.id_rt_data;
      id_ex_d.imm      = bus.id_imm;
      id_ex_d.rs       = bus.id_rs;
      id_ex_d.rt       = bus.id_rt;
      id_ex_d.rd       = bus.id_rd;
      id_ex_d.aluop    = bus.id_aluop;
      id_ex_d.funct    = bus.id_funct;
      id_ex_d.alusrc   = bus.id_alusrc;
      id_ex_d.regdst   = bus.id_regdst;
      id_ex_d.regwrite = bus.id_regwrite;
      id_ex_d.memread  = bus.id_memread;
      id_ex_d.memwrite = bus.id_memwrite;
      id_ex_d.memtoreg = bus.id_memtoreg;
    end
  end

  always_comb begin
    ex_mem_d = ex_mem_q;
    if (!bus.stall) begin
      ex_mem_d.valid      = id_ex_q.valid;
      ex_mem_d.regwrite   = id_ex_q.regwrite & id_ex_q.valid;
      ex_mem_d.memread    = id_ex_q.memread  & id_ex_q.valid;
      ex_mem_d.memwrite   = id_ex_q.memwrite & id_ex_q.valid;
      ex_mem_d.memtoreg   = id_ex_q.memtoreg & id_ex_q.valid;
      ex_mem_d.zero       = bus.alu_zero;
      ex_mem_d.illegal    = w_illegal;
      ex_mem_d.alu_res    = bus.alu_res;
      ex_mem_d.store_data = w_rt_val;
      ex_mem_d.rd         = id_ex_q.regdst ? id_ex_q.rd : id_ex_q.rt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
    end
  end

  assign bus.alu_in0        = w_rs_val;
  assign bus.alu_in1        = id_ex_q.alusrc ? id_ex_q.imm : w_rt_val;
  assign bus.alu_op         = w_alu_op;
  assign bus.load_use       = w_load_use;
  assign bus.mem_valid      = ex_mem_q.valid;
  assign bus.mem_regwrite   = ex_mem_q.regwrite;
  assign bus.mem_memread    = ex_mem_q.memread;
  assign bus.mem_memwrite   = ex_mem_q.memwrite;
  assign bus.mem_memtoreg   = ex_mem_q.memtoreg;
  assign bus.mem_alu_res    = ex_mem_q.alu_res;
  assign bus.mem_zero       = ex_mem_q.zero;
  assign bus.mem_store_data = ex_mem_q.store_data;
  assign bus.mem_rd         = ex_mem_q.rd;
  assign bus.illegal_funct  = ex_mem_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ex_stage_ctrl : directed bench for ex_stage_ctrl with an ALU model |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_ex_stage_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  ex_stage_ctrl_if #(.W(32), .RA(5)) bus ();

  ex_stage_ctrl #(.W(32), .RA(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU; slt compares unsigned.
  always_comb begin
    case (bus.alu_op)
      4'b0000: bus.alu_res = bus.alu_in0 & bus.alu_in1;
      4'b0001: bus.alu_res = bus.alu_in0 | bus.alu_in1;
      4'b0010: bus.alu_res = bus.alu_in0 + bus.alu_in1;
      4'b0110: bus.alu_res = bus.alu_in0 - bus.alu_in1;
      4'b0111: bus.alu_res = (bus.alu_in0 < bus.alu_in1) ? 32'd1 : 32'd0;
      4'b1100: bus.alu_res = ~(bus.alu_in0 | bus.alu_in1);
      default: bus.alu_res = 32'd0;
    endcase
  end
  assign bus.alu_zero = (bus.alu_res == 32'd0);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    bus.id_valid = 0; bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0;
    bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0; bus.id_aluop = 0; bus.id_funct = 0;
    bus.id_alusrc = 0; bus.id_regdst = 0; bus.id_regwrite = 0;
    bus.id_memread = 0; bus.id_memwrite = 0; bus.id_memtoreg = 0;
  endtask

  task automatic set_r(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] rsd, input logic [31:0] rtd, input logic [5:0] fn);
    clear_id();
    bus.id_valid = 1; bus.id_rd = rd; bus.id_rs = rs; bus.id_rt = rt;
    bus.id_rs_data = rsd; bus.id_rt_data = rtd; bus.id_funct = fn;
    bus.id_aluop = 2'b10; bus.id_regdst = 1; bus.id_regwrite = 1;
  endtask

  task automatic drain();
    clear_id();
    bus.wb_regwrite = 0; bus.wb_rd = 0; bus.wb_data = 0;
    step();
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.stall = 0; bus.flush = 0;
    bus.wb_regwrite = 0; bus.wb_rd = 0; bus.wb_data = 0;
    clear_id();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_valid, bus.mem_regwrite, bus.mem_memread, bus.mem_memwrite, bus.mem_memtoreg,
         bus.mem_alu_res, bus.mem_zero, bus.mem_store_data, bus.mem_rd, bus.illegal_funct,
         bus.load_use} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got mem_valid=%b regwrite=%b res=%h rd=%h illegal=%b expected all zero",
               bus.mem_valid, bus.mem_regwrite, bus.mem_alu_res, bus.mem_rd, bus.illegal_funct);
    end
    checks++;
    if (bus.alu_op !== 4'b0010) begin
      failures++; $display("FAIL reset_alu_op: got %b expected 0010", bus.alu_op);
    end
    step();
    @(negedge clk) rst_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    drain();
    set_r(5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 6'b100000);
    step();
    clear_id(); #1;
    checks++;
    if (bus.alu_op !== 4'b0010) begin failures++; $display("FAIL add_alu_op: got %b expected 0010", bus.alu_op); end
    checks++;
    if (bus.alu_in0 !== 32'd5) begin failures++; $display("FAIL add_in0: got %0d expected 5", bus.alu_in0); end
    checks++;
    if (bus.alu_in1 !== 32'd7) begin failures++; $display("FAIL add_in1: got %0d expected 7", bus.alu_in1); end
    step();
    checks++;
    if (bus.mem_alu_res !== 32'd12 || bus.mem_rd !== 5'd3 || bus.mem_regwrite !== 1'b1 || bus.mem_valid !== 1'b1) begin
      failures++;
      $display("FAIL add_mem: got res=%0d rd=%0d regwrite=%b valid=%b expected 12 3 1 1",
               bus.mem_alu_res, bus.mem_rd, bus.mem_regwrite, bus.mem_valid);
    end
  endtask

  task automatic test_fwd_exmem();
    drain();
    set_r(5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 6'b100000);
    step();
    set_r(5'd4, 5'd3, 5'd1, 32'd999, 32'd1, 6'b100010);
    step();
    clear_id(); #1;
    checks++;
    if (bus.alu_in0 !== 32'd12) begin failures++; $display("FAIL fwd_exmem_in0: got %0d expected 12", bus.alu_in0); end
    checks++;
    if (bus.alu_op !== 4'b0110) begin failures++; $display("FAIL fwd_exmem_op: got %b expected 0110", bus.alu_op); end
    step();
    checks++;
    if (bus.mem_alu_res !== 32'd11 || bus.mem_rd !== 5'd4) begin
      failures++; $display("FAIL fwd_exmem_res: got res=%0d rd=%0d expected 11 4", bus.mem_alu_res, bus.mem_rd);
    end
  endtask

  task automatic test_fwd_wb();
    drain();
    set_r(5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 6'b100000);
    step();
    clear_id();
    step();
    set_r(5'd4, 5'd3, 5'd1, 32'd999, 32'd1, 6'b100010);
    step();
    bus.wb_regwrite = 1; bus.wb_rd = 5'd3; bus.wb_data = 32'd12;
    clear_id(); #1;
    checks++;
    if (bus.alu_in0 !== 32'd12) begin failures++; $display("FAIL fwd_wb_in0: got %0d expected 12", bus.alu_in0); end
    step();
    checks++;
    if (bus.mem_alu_res !== 32'd11) begin failures++; $display("FAIL fwd_wb_res: got %0d expected 11", bus.mem_alu_res); end
    bus.wb_regwrite = 0;
  endtask

  task automatic test_fwd_priority();
    drain();
    set_r(5'd3, 5'd1, 5'd2, 32'h10, 32'h0, 6'b100000);
    step();
    set_r(5'd7, 5'd3, 5'd3, 32'd999, 32'd888, 6'b100000);
    step();
    bus.wb_regwrite = 1; bus.wb_rd = 5'd3; bus.wb_data = 32'h20;
    clear_id(); #1;
    checks++;
    if (bus.alu_in0 !== 32'h10) begin failures++; $display("FAIL fwd_prio_in0: got %h expected 10", bus.alu_in0); end
    checks++;
    if (bus.alu_in1 !== 32'h10) begin failures++; $display("FAIL fwd_prio_in1: got %h expected 10", bus.alu_in1); end
    step();
    checks++;
    if (bus.mem_store_data !== 32'h10 || bus.mem_alu_res !== 32'h20) begin
      failures++; $display("FAIL fwd_prio_mem: got store=%h res=%h expected 10 20", bus.mem_store_data, bus.mem_alu_res);
    end
    bus.wb_regwrite = 0;
    drain();
    set_r(5'd0, 5'd1, 5'd2, 32'h55, 32'h0, 6'b100000);
    step();
    set_r(5'd8, 5'd0, 5'd2, 32'h0, 32'd3, 6'b100000);
    step();
    bus.wb_regwrite = 1; bus.wb_rd = 5'd0; bus.wb_data = 32'h77;
    clear_id(); #1;
    checks++;
    if (bus.alu_in0 !== 32'h0) begin failures++; $display("FAIL fwd_r0_in0: got %h expected 0", bus.alu_in0); end
    step();
    checks++;
    if (bus.mem_alu_res !== 32'd3) begin failures++; $display("FAIL fwd_r0_res: got %h expected 3", bus.mem_alu_res); end
    bus.wb_regwrite = 0;
  endtask

  task automatic test_load_use();
    drain();
    clear_id();
    bus.id_valid = 1; bus.id_rs = 5'd1; bus.id_rt = 5'd5; bus.id_rs_data = 32'h100; bus.id_rt_data = 32'h33;
    bus.id_imm = 32'd8; bus.id_aluop = 2'b00; bus.id_alusrc = 1; bus.id_memread = 1;
    bus.id_memtoreg = 1; bus.id_regwrite = 1;
    step();
    set_r(5'd6, 5'd7, 5'd2, 32'd1, 32'd4, 6'b100000); #1;
    checks++;
    if (bus.load_use !== 1'b0) begin failures++; $display("FAIL lu_independent: got %b expected 0", bus.load_use); end
    checks++;
    if (bus.alu_in1 !== 32'd8 || bus.alu_in0 !== 32'h100) begin
      failures++; $display("FAIL lw_operands: got in0=%h in1=%h expected 100 8", bus.alu_in0, bus.alu_in1);
    end
    set_r(5'd6, 5'd5, 5'd2, 32'd999, 32'd4, 6'b100000); #1;
    checks++;
    if (bus.load_use !== 1'b1) begin failures++; $display("FAIL lu_assert: got %b expected 1", bus.load_use); end
    step();
    checks++;
    if (bus.load_use !== 1'b0) begin failures++; $display("FAIL lu_one_cycle: got %b expected 0", bus.load_use); end
    checks++;
    if (bus.mem_alu_res !== 32'h108 || bus.mem_rd !== 5'd5 || bus.mem_memread !== 1'b1 ||
        bus.mem_memtoreg !== 1'b1 || bus.mem_store_data !== 32'h33) begin
      failures++;
      $display("FAIL lw_mem: got res=%h rd=%0d memread=%b memtoreg=%b store=%h expected 108 5 1 1 33",
               bus.mem_alu_res, bus.mem_rd, bus.mem_memread, bus.mem_memtoreg, bus.mem_store_data);
    end
    step();
    clear_id();
    bus.wb_regwrite = 1; bus.wb_rd = 5'd5; bus.wb_data = 32'hAB; #1;
    checks++;
    if (bus.mem_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble: got mem_valid=%b expected 0", bus.mem_valid); end
    checks++;
    if (bus.alu_in0 !== 32'hAB) begin failures++; $display("FAIL lu_fwd_wb: got %h expected ab", bus.alu_in0); end
    step();
    checks++;
    if (bus.mem_alu_res !== 32'hAF || bus.mem_rd !== 5'd6 || bus.mem_valid !== 1'b1) begin
      failures++; $display("FAIL lu_add_res: got res=%h rd=%0d valid=%b expected af 6 1",
                           bus.mem_alu_res, bus.mem_rd, bus.mem_valid);
    end
    bus.wb_regwrite = 0;
  endtask

  task automatic test_flush();
    drain();
    set_r(5'd9, 5'd1, 5'd2, 32'd1, 32'd1, 6'b100000);
    bus.flush = 1;
    step();
    bus.flush = 0;
    clear_id();
    step();
    checks++;
    if (bus.mem_regwrite !== 1'b0 || bus.mem_valid !== 1'b0) begin
      failures++; $display("FAIL flush_bubble: got regwrite=%b valid=%b expected 0 0", bus.mem_regwrite, bus.mem_valid);
    end
    set_r(5'd9, 5'd1, 5'd2, 32'd1, 32'd1, 6'b100000);
    step();
    clear_id();
    bus.flush = 1;
    step();
    bus.flush = 0;
    checks++;
    if (bus.mem_regwrite !== 1'b1 || bus.mem_rd !== 5'd9) begin
      failures++; $display("FAIL flush_keeps_exmem: got regwrite=%b rd=%0d expected 1 9", bus.mem_regwrite, bus.mem_rd);
    end
  endtask

  task automatic test_stall();
    drain();
    set_r(5'd10, 5'd1, 5'd2, 32'd2, 32'd3, 6'b100000);
    step();
    set_r(5'd11, 5'd13, 5'd14, 32'd1, 32'd1, 6'b100000);
    step();
    bus.stall = 1;
    set_r(5'd12, 5'd15, 5'd16, 32'd100, 32'd100, 6'b100000);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.mem_alu_res !== 32'd5 || bus.mem_rd !== 5'd10 || bus.mem_regwrite !== 1'b1 || bus.mem_valid !== 1'b1) begin
        failures++; $display("FAIL stall_hold_%0d: got res=%0d rd=%0d regwrite=%b valid=%b expected 5 10 1 1",
                             i, bus.mem_alu_res, bus.mem_rd, bus.mem_regwrite, bus.mem_valid);
      end
    end
    bus.stall = 0;
    clear_id();
    step();
    checks++;
    if (bus.mem_alu_res !== 32'd2 || bus.mem_rd !== 5'd11) begin
      failures++; $display("FAIL stall_idex_hold: got res=%0d rd=%0d expected 2 11", bus.mem_alu_res, bus.mem_rd);
    end
  endtask

  task automatic test_decode();
    logic [12:0] tbl [10];
    logic [12:0] e;
    tbl = '{ {2'b00, 6'b000011, 4'b0010, 1'b0}, {2'b01, 6'b000011, 4'b0110, 1'b0},
             {2'b11, 6'b000011, 4'b0001, 1'b0}, {2'b10, 6'b100000, 4'b0010, 1'b0},
             {2'b10, 6'b100010, 4'b0110, 1'b0}, {2'b10, 6'b100100, 4'b0000, 1'b0},
             {2'b10, 6'b100101, 4'b0001, 1'b0}, {2'b10, 6'b101010, 4'b0111, 1'b0},
             {2'b10, 6'b100111, 4'b1100, 1'b0}, {2'b10, 6'b000011, 4'b0010, 1'b1} };
    drain();
    for (int i = 0; i < 10; i++) begin
      e = tbl[i];
      set_r(5'd20, 5'd1, 5'd2, 32'd9, 32'd4, e[10:5]);
      bus.id_aluop = e[12:11];
      step();
      clear_id(); #1;
      checks++;
      if (bus.alu_op !== e[4:1]) begin
        failures++; $display("FAIL decode_op_%0d: got %b expected %b", i, bus.alu_op, e[4:1]);
      end
      step();
      checks++;
      if (bus.illegal_funct !== e[0]) begin
        failures++; $display("FAIL decode_illegal_%0d: got %b expected %b", i, bus.illegal_funct, e[0]);
      end
    end
    set_r(5'd20, 5'd1, 5'd2, 32'd9, 32'd4, 6'b000011);
    bus.id_valid = 0;
    step();
    clear_id();
    step();
    checks++;
    if (bus.illegal_funct !== 1'b0 || bus.mem_valid !== 1'b0) begin
      failures++; $display("FAIL illegal_invalid: got illegal=%b valid=%b expected 0 0", bus.illegal_funct, bus.mem_valid);
    end
  endtask

  task automatic test_async_reset();
    drain();
    set_r(5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 6'b100000);
    step();
    set_r(5'd4, 5'd6, 5'd7, 32'd40, 32'd2, 6'b100000);
    step();
    clear_id();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_regwrite !== 1'b0 || bus.mem_valid !== 1'b0 || bus.mem_alu_res !== 32'd0 || bus.mem_rd !== 5'd0) begin
      failures++; $display("FAIL async_reset_mem: got regwrite=%b valid=%b res=%h rd=%0d expected 0 0 0 0",
                           bus.mem_regwrite, bus.mem_valid, bus.mem_alu_res, bus.mem_rd);
    end
    checks++;
    if (bus.alu_in0 !== 32'd0) begin failures++; $display("FAIL async_reset_idex: got %h expected 0", bus.alu_in0); end
    #1 rst_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_add();
    test_fwd_exmem();
    test_fwd_wb();
    test_fwd_priority();
    test_load_use();
    test_flush();
    test_stall();
    test_decode();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
